// File: rtl/add_arbiter.sv
// Two-requester front end for a shared combinational carry-lookahead adder.
// Requests are arbitrated round-robin, the winner's operands are latched,
// the sum is captured one cycle later, and the response is held until the
// granted requester accepts it.
module add_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_z,
   output logic             resp_cout,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   input  logic [WIDTH-1:0] add_z,
   output logic             busy,
   output logic             grant_id
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             lastGrant_q, lastGrant_d;
   logic             grant_q, grant_d;
   logic [WIDTH-1:0] opA_q, opA_d;
   logic [WIDTH-1:0] opB_q, opB_d;
   logic [WIDTH-1:0] respZ_q, respZ_d;
   logic             respCout_q, respCout_d;
   logic             winner;
   logic             accept;

   // Pick the winner: a lone requester wins outright, a tie goes to the
   // requester that was not served last.
   always_comb begin
      winner = 1'b0;
      case (req_valid)
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~lastGrant_q;
         default: winner = 1'b0;
      endcase
   end

   // Only the winner sees ready, and only while the adder is free.
   always_comb begin
      req_ready = 2'b00;
      accept    = 1'b0;
      if (state_q == IDLE && req_valid != 2'b00) begin
         req_ready = winner ? 2'b10 : 2'b01;
         accept    = 1'b1;
      end
   end

   // Next-state logic: latch operands on accept, capture the sum in CALC,
   // hold the response in RESP until the granted requester takes it.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      grant_d     = grant_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      respZ_d     = respZ_q;
      respCout_d  = respCout_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               grant_d = winner;
               opA_d   = winner ? req1_a : req0_a;
               opB_d   = winner ? req1_b : req0_b;
               state_d = CALC;
            end
         end
         CALC: begin
            respZ_d    = add_z;
            respCout_d = (opA_q[WIDTH-1] & opB_q[WIDTH-1]) |
                         ((opA_q[WIDTH-1] ^ opB_q[WIDTH-1]) & ~add_z[WIDTH-1]);
            state_d    = RESP;
         end
         RESP: begin
            if (resp_ready[grant_q]) begin
               lastGrant_d = grant_q;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight and primes the
   // pointer so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         grant_q     <= 1'b0;
         opA_q       <= '0;
         opB_q       <= '0;
         respZ_q     <= '0;
         respCout_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         grant_q     <= grant_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         respZ_q     <= respZ_d;
         respCout_q  <= respCout_d;
      end
   end

   assign resp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_z     = respZ_q;
   assign resp_cout  = respCout_q;
   assign add_a      = opA_q;
   assign add_b      = opB_q;
   assign busy       = (state_q != IDLE);
   assign grant_id   = grant_q;

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: supplies the adder, drives directed and random
// requests, and checks against a round-robin/arithmetic reference model.
module tb_add_arbiter;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [1:0]    resp_valid;
   logic [1:0]    resp_ready;
   logic [W-1:0]  resp_z;
   logic          resp_cout;
   logic [W-1:0]  add_a, add_b, add_z;
   logic          busy;
   logic          grant_id;

   int   checks = 0;
   int   failures = 0;
   logic lastGrantModel;

   add_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_z(resp_z), .resp_cout(resp_cout),
      .add_a(add_a), .add_b(add_b), .add_z(add_z),
      .busy(busy), .grant_id(grant_id)
   );

   // The shared adder lives outside the arbiter.
   assign add_z = add_a + add_b;

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   // Safety net in case something stalls the whole run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic expWinner(input logic [1:0] v);
      if (v == 2'b10) return 1'b1;
      if (v == 2'b11) return ~lastGrantModel;
      return 1'b0;
   endfunction

   function automatic logic [W:0] expSum(input logic [W-1:0] a, input logic [W-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   function automatic logic [1:0] oneHot(input logic w);
      return w ? 2'b10 : 2'b01;
   endfunction

   task automatic applyStimulus(input logic [1:0] v, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input logic [W-1:0] a1, input logic [W-1:0] b1, output logic [1:0] readyObs);
      req_valid = v;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      #1 readyObs = req_ready;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
   endtask

   task automatic waitResp(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (resp_valid == 2'b00 && cyc < 20);
   endtask

   task automatic releaseResp(input logic [1:0] rr);
      resp_ready = rr;
      @(posedge clk);
      #1 resp_ready = 2'b00;
      @(negedge clk);
   endtask

   task automatic resetDut();
      rst = 1'b1;
      req_valid = 2'b00;
      resp_ready = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      lastGrantModel = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b00;
      resp_ready = 2'b00;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy actual=%b required=0", busy); end
      checks++; if (resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_resp_valid actual=%b required=00", resp_valid); end
      checks++; if (add_a !== '0 || add_b !== '0) begin failures++; $display("[TB] FAIL reset_add_ops actual=%h/%h required=0/0", add_a, add_b); end
      checks++; if (resp_z !== '0 || resp_cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_resp actual=%h/%b required=0/0", resp_z, resp_cout); end
      checks++; if (grant_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_grant actual=%b required=0", grant_id); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL reset_ready_idle actual=%b required=00", req_ready); end
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin failures++; $display("[TB] FAIL reset_ready_tie actual=%b required=01", req_ready); end
      req_valid = 2'b00;
      @(posedge clk);
      #1 rst = 1'b0;
      lastGrantModel = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [1:0] ro;
      int cyc;
      applyStimulus(2'b01, 16'h1234, 16'h0F0F, 16'h0000, 16'h0000, ro);
      checks++; if (ro !== 2'b01) begin failures++; $display("[TB] FAIL single_ready actual=%b required=01", ro); end
      waitResp(cyc);
      checks++; if (cyc !== 2) begin failures++; $display("[TB] FAIL single_latency actual=%0d required=2", cyc); end
      checks++; if (resp_valid !== 2'b01) begin failures++; $display("[TB] FAIL single_valid actual=%b required=01", resp_valid); end
      checks++; if (resp_z !== 16'h2143 || resp_cout !== 1'b0) begin failures++; $display("[TB] FAIL single_sum actual=%h/%b required=2143/0", resp_z, resp_cout); end
      checks++; if (grant_id !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL single_grant_busy actual=%b/%b required=0/1", grant_id, busy); end
      releaseResp(2'b01);
      lastGrantModel = 1'b0;
      checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL single_done actual=%b/%b required=0/00", busy, resp_valid); end
   endtask

   task automatic test_overflow();
      logic [1:0] ro;
      int cyc;
      applyStimulus(2'b10, 16'h0000, 16'h0000, 16'hFFFF, 16'h0001, ro);
      checks++; if (ro !== 2'b10) begin failures++; $display("[TB] FAIL ovf_ready actual=%b required=10", ro); end
      waitResp(cyc);
      checks++; if (resp_valid !== 2'b10) begin failures++; $display("[TB] FAIL ovf_valid actual=%b required=10", resp_valid); end
      checks++; if (resp_z !== 16'h0000 || resp_cout !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sum actual=%h/%b required=0000/1", resp_z, resp_cout); end
      checks++; if (grant_id !== 1'b1) begin failures++; $display("[TB] FAIL ovf_grant actual=%b required=1", grant_id); end
      releaseResp(2'b10);
      lastGrantModel = 1'b1;
   endtask

   task automatic test_tie();
      logic [1:0] ro;
      logic [W-1:0] a0, b0, a1, b1;
      logic [W:0] s;
      logic w;
      int cyc;
      resetDut();
      for (int i = 0; i < 4; i++) begin
         a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
         w = expWinner(2'b11);
         s = w ? expSum(a1, b1) : expSum(a0, b0);
         applyStimulus(2'b11, a0, b0, a1, b1, ro);
         checks++; if (ro !== oneHot(w)) begin failures++; $display("[TB] FAIL tie_ready actual=%b required=%b", ro, oneHot(w)); end
         waitResp(cyc);
         req_valid = 2'b11;
         #1;
         checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL tie_ready_busy actual=%b required=00", req_ready); end
         req_valid = 2'b00;
         checks++; if (grant_id !== logic'(i % 2)) begin failures++; $display("[TB] FAIL tie_alternate actual=%b required=%0d", grant_id, i % 2); end
         checks++; if (resp_valid !== oneHot(w)) begin failures++; $display("[TB] FAIL tie_valid actual=%b required=%b", resp_valid, oneHot(w)); end
         checks++; if ({resp_cout, resp_z} !== s) begin failures++; $display("[TB] FAIL tie_sum actual=%h required=%h", {resp_cout, resp_z}, s); end
         releaseResp(2'b11);
         lastGrantModel = w;
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] ro;
      logic [W-1:0] a, b;
      logic [W:0] s;
      int cyc;
      a = W'($urandom); b = W'($urandom);
      s = expSum(a, b);
      applyStimulus(2'b01, a, b, 16'h0000, 16'h0000, ro);
      waitResp(cyc);
      for (int i = 0; i < 5; i++) begin
         resp_ready = 2'b10;
         req_valid = 2'b11;
         @(posedge clk);
         @(negedge clk);
         checks++; if (resp_valid !== 2'b01 || busy !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold actual=%b/%b required=01/1", resp_valid, busy); end
         checks++; if ({resp_cout, resp_z} !== s) begin failures++; $display("[TB] FAIL bp_stable actual=%h required=%h", {resp_cout, resp_z}, s); end
         checks++; if (req_ready !== 2'b00) begin failures++; $display("[TB] FAIL bp_ready actual=%b required=00", req_ready); end
      end
      req_valid = 2'b00;
      releaseResp(2'b01);
      lastGrantModel = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_done actual=%b required=0", busy); end
   endtask

   task automatic test_operand_change();
      logic [1:0] ro;
      logic [W-1:0] a, b;
      logic [W:0] s;
      int cyc;
      a = W'($urandom); b = W'($urandom);
      s = expSum(a, b);
      applyStimulus(2'b01, a, b, 16'h0000, 16'h0000, ro);
      req0_a = ~a; req0_b = ~b; req_valid = 2'b01;
      #1;
      checks++; if (add_a !== a || add_b !== b) begin failures++; $display("[TB] FAIL opchg_latched actual=%h/%h required=%h/%h", add_a, add_b, a, b); end
      waitResp(cyc);
      checks++; if ({resp_cout, resp_z} !== s) begin failures++; $display("[TB] FAIL opchg_sum actual=%h required=%h", {resp_cout, resp_z}, s); end
      req_valid = 2'b00;
      releaseResp(2'b01);
      lastGrantModel = 1'b0;
   endtask

   task automatic test_reset_in_calc();
      logic [1:0] ro;
      applyStimulus(2'b10, 16'h0000, 16'h0000, 16'hABCD, 16'h1111, ro);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      lastGrantModel = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL rstcalc_idle actual=%b/%b required=0/00", busy, resp_valid); end
      checks++; if (resp_z !== '0 || resp_cout !== 1'b0 || grant_id !== 1'b0) begin failures++; $display("[TB] FAIL rstcalc_clear actual=%h/%b/%b required=0/0/0", resp_z, resp_cout, grant_id); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL rstcalc_stale actual=%b required=00", resp_valid); end
      end
   endtask

   task automatic test_drop();
      logic [1:0] ro;
      logic [W-1:0] a0, b0, a1, b1;
      logic [W:0] s;
      logic w;
      int cyc;
      req_valid = 2'b10;
      #2 req_valid = 2'b00;
      @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || resp_valid !== 2'b00) begin failures++; $display("[TB] FAIL drop_nochange actual=%b/%b required=0/00", busy, resp_valid); end
      a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
      w = expWinner(2'b11);
      s = w ? expSum(a1, b1) : expSum(a0, b0);
      applyStimulus(2'b11, a0, b0, a1, b1, ro);
      checks++; if (ro !== oneHot(w)) begin failures++; $display("[TB] FAIL drop_tie actual=%b required=%b", ro, oneHot(w)); end
      waitResp(cyc);
      checks++; if ({resp_cout, resp_z} !== s) begin failures++; $display("[TB] FAIL drop_sum actual=%h required=%h", {resp_cout, resp_z}, s); end
      releaseResp(oneHot(w));
      lastGrantModel = w;
   endtask

   task automatic test_random();
      logic [1:0] ro, v;
      logic [W-1:0] a0, b0, a1, b1;
      logic [W:0] s;
      logic w;
      int cyc, stall;
      for (int i = 0; i < 24; i++) begin
         v = 2'($urandom_range(1, 3));
         a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
         if ($urandom_range(0, 3) == 0) begin a0 = '1; a1 = '1; end
         w = expWinner(v);
         s = w ? expSum(a1, b1) : expSum(a0, b0);
         applyStimulus(v, a0, b0, a1, b1, ro);
         checks++; if (ro !== oneHot(w)) begin failures++; $display("[TB] FAIL rnd_ready actual=%b required=%b", ro, oneHot(w)); end
         waitResp(cyc);
         checks++; if (cyc !== 2) begin failures++; $display("[TB] FAIL rnd_latency actual=%0d required=2", cyc); end
         checks++; if (resp_valid !== oneHot(w) || grant_id !== w) begin failures++; $display("[TB] FAIL rnd_valid actual=%b/%b required=%b/%b", resp_valid, grant_id, oneHot(w), w); end
         checks++; if ({resp_cout, resp_z} !== s) begin failures++; $display("[TB] FAIL rnd_sum actual=%h required=%h", {resp_cout, resp_z}, s); end
         stall = $urandom_range(0, 2);
         for (int j = 0; j < stall; j++) begin
            resp_ready = oneHot(~w);
            @(posedge clk);
            @(negedge clk);
            checks++; if (resp_valid !== oneHot(w)) begin failures++; $display("[TB] FAIL rnd_stall actual=%b required=%b", resp_valid, oneHot(w)); end
         end
         releaseResp(oneHot(w) | 2'($urandom_range(0, 3)));
         lastGrantModel = w;
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      rst = 1'b1;
      req_valid = 2'b00;
      resp_ready = 2'b00;
      lastGrantModel = 1'b1;
      test_reset();
      test_single();
      test_overflow();
      test_tie();
      test_backpressure();
      test_operand_change();
      test_reset_in_calc();
      test_drop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width of the shared cla adder.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester request accept.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands of requester 0/1.
REQ-007 SHALL have port resp_valid  output  2  per-requester result valid.
REQ-008 SHALL have port resp_ready  input  2  per-requester result accept.
REQ-009 SHALL have port resp_z  output  WIDTH  registered sum, shared by both requesters.
REQ-010 SHALL have port resp_cout  output  1  registered unsigned carry-out of the sum.
REQ-011 SHALL have ports add_a, add_b  output  WIDTH  operands to the combinational cla adder.
REQ-012 SHALL have port add_z  input  WIDTH  sum returned by the cla adder.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port grant_id  output  1  requester currently owning the adder (last granted when IDLE).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, RESP; single-cycle CALC.
REQ-016 IDLE: winner = requester with req_valid set; if both set, winner = requester not granted last (round-robin pointer).
REQ-017 IDLE: req_ready SHALL be 1 only for the winner, combinationally, and 2'b00 when no req_valid; req_ready SHALL be 2'b00 in CALC and RESP.
REQ-018 Handshake edge (IDLE, req_valid[w] & req_ready[w]): latch winner's a/b into operand registers, set grant_id=w, go to CALC.
REQ-019 add_a/add_b SHALL be driven from the operand registers at all times (never directly from req inputs).
REQ-020 CALC: at end of cycle, load resp_z=add_z and resp_cout=(a[MSB]&b[MSB]) | ((a[MSB]^b[MSB]) & ~add_z[MSB]) from operand registers; go to RESP.
REQ-021 Latency: handshake in cycle k -> resp_valid[grant_id]=1 in cycle k+2.
REQ-022 RESP: resp_valid[grant_id]=1, other bit 0; resp_z/resp_cout held stable until resp_ready[grant_id]=1.
REQ-023 RESP with resp_ready[grant_id]=1: go to IDLE next cycle; round-robin pointer updated to grant_id; resp_ready of the non-granted requester SHALL be ignored.
REQ-024 No back-to-back accept: a new request is accepted no earlier than the IDLE cycle following the response handshake (throughput 1 op per 3 cycles minimum).
REQ-025 Requester inputs (req_valid, operands) changing during CALC/RESP SHALL NOT affect the in-flight result.
REQ-026 Arithmetic modulo 2^WIDTH; wrap-around reported only via resp_cout (e.g. 0xFFFF+0x0001 -> z=0x0000, cout=1).
REQ-027 A requester dropping req_valid before handshake SHALL lose arbitration with no state change.

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE, pointer so requester 0 wins the first tie, grant_id=0, operand registers 0, resp_z=0, resp_cout=0.
REQ-029 During and after reset: req_ready per REQ-017, resp_valid=2'b00, busy=0, add_a=add_b=0.
REQ-030 rst asserted mid-operation (CALC or RESP) SHALL abort the operation; no resp_valid is emitted for it.

Verification
REQ-031 Single request: req_valid=01, a=0x1234, b=0x0F0F, resp_ready=01 -> resp_valid=01 two cycles after accept, resp_z=0x2143, resp_cout=0.
REQ-032 Overflow: requester 1, a=0xFFFF, b=0x0001 -> resp_valid=10, resp_z=0x0000, resp_cout=1.
REQ-033 Tie after reset: req_valid=11 held -> grants alternate 0,1,0,1 over four operations; req_ready never 11.
REQ-034 Backpressure: resp_ready=00 for 5 cycles in RESP -> resp_valid and resp_z stable, busy=1, req_ready=00; completes on resp_ready=grant bit.
REQ-035 Operand change after accept: req0_a changed in CALC -> resp_z reflects latched operands.
REQ-036 Reset in CALC: rst=1 one cycle -> IDLE, resp_valid=00, resp_z=0, no stale response afterwards.
